// File: rtl/myo_spi_frame_master.sv
// SPI mode-1 frame engine for one myocontrol channel: fetches FRAME_WORDS words from the
// command RAM, shifts each out MSB first on the selected board and returns every received word.
module myo_spi_frame_master #(
    parameter int CLK_DIV     = 25,
    parameter int WORD_BITS   = 16,
    parameter int FRAME_WORDS = 12,
    parameter int NUM_SLAVES  = 8,
    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    localparam int IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SEL_W-1:0]      slave_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  sel_err,
    output logic                  tx_rd,
    output logic [IDX_W-1:0]      word_idx,
    input  logic [WORD_BITS-1:0]  tx_data,
    output logic [WORD_BITS-1:0]  rx_data,
    output logic                  rx_valid,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_SLAVES-1:0] ss_n
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(WORD_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_WORDS - 1);
    localparam logic [SEL_W:0]   NS_VAL   = (SEL_W + 1)'(NUM_SLAVES);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FETCH, S_SHIFT, S_GAP, S_TAIL
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0]   tx_sh_q, tx_sh_d;
    logic [WORD_BITS-2:0]   rx_sh_q, rx_sh_d;
    logic [IDX_W-1:0]       word_idx_q, word_idx_d;
    logic [WORD_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   tx_rd_q, tx_rd_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   sel_err_q, sel_err_d;
    logic                   sck_q, sck_d;
    logic                   mosi_q, mosi_d;
    logic [NUM_SLAVES-1:0]  ss_n_q, ss_n_d;
    logic                   sel_ok;

    assign sel_ok = ({1'b0, slave_sel} < NS_VAL);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        word_idx_d = word_idx_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_rd_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sel_err_d  = 1'b0;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;

        case (state_q)
            S_IDLE: begin
                // abort in the same cycle as start suppresses the request entirely
                if (start && !abort) begin
                    if (sel_ok) begin
                        word_idx_d = '0;
                        ss_n_d     = ~(NUM_SLAVES'(1) << slave_sel);
                        busy_d     = 1'b1;
                        tx_rd_d    = 1'b1;
                        state_d    = S_LOAD;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            S_LOAD: state_d = S_FETCH;
            S_FETCH: begin
                tx_sh_d   = tx_data;
                cnt_d     = CNT_MAX;
                bit_cnt_d = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_MAX;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        mosi_d  = tx_sh_q[WORD_BITS-1];
                        tx_sh_d = tx_sh_q << 1;
                    end else begin
                        rx_sh_d   = (WORD_BITS-1)'({rx_sh_q, miso});
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            rx_data_d  = {rx_sh_q, miso};
                            rx_valid_d = 1'b1;
                            state_d    = S_GAP;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    if (word_idx_q == IDX_LAST) begin
                        cnt_d   = CNT_MAX;
                        state_d = S_TAIL;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                        tx_rd_d    = 1'b1;
                        state_d    = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_TAIL: begin
                if (cnt_q == '0) begin
                    ss_n_d  = '1;
                    mosi_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort overrides whatever the active state decided this cycle
        if (abort && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            ss_n_d     = '1;
            sck_d      = 1'b0;
            mosi_d     = 1'b0;
            busy_d     = 1'b0;
            tx_rd_d    = 1'b0;
            rx_valid_d = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            word_idx_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_rd_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sel_err_q  <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            word_idx_q <= word_idx_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_rd_q    <= tx_rd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sel_err_q  <= sel_err_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sel_err  = sel_err_q;
    assign tx_rd    = tx_rd_q;
    assign word_idx = word_idx_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;

endmodule

// File: tb/tb_myo_spi_frame_master.sv
// Directed bench for myo_spi_frame_master: table of whole frames plus hand-written
// sequences for start-while-busy, illegal select, abort and mid-frame reset.
module tb_myo_spi_frame_master;

    localparam int CD = 2;
    localparam int WB = 16;
    localparam int FW = 12;
    localparam int NS = 6;
    localparam int FRAME_LAT = FW * (2 + 2 * WB * CD + CD) + CD + 1;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [2:0]    slave_sel = 3'd0;
    logic          busy, done, sel_err, tx_rd, rx_valid, sck, mosi, miso;
    logic [3:0]    word_idx;
    logic [WB-1:0] tx_data = '0;
    logic [WB-1:0] rx_data;
    logic [NS-1:0] ss_n;

    myo_spi_frame_master #(
        .CLK_DIV(CD), .WORD_BITS(WB), .FRAME_WORDS(FW), .NUM_SLAVES(NS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .slave_sel(slave_sel),
        .busy(busy), .done(done), .sel_err(sel_err), .tx_rd(tx_rd), .word_idx(word_idx),
        .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
        .sck(sck), .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // slave model: RAM returns base+index one cycle after tx_rd, miso echoes (or inverts) mosi
    logic [WB-1:0] cur_base = '0;
    bit            mon_inv = 1'b0;
    logic [NS-1:0] exp_ss_n = '1;

    assign miso = mon_inv ? ~mosi : mosi;

    always @(posedge clk) begin
        if (tx_rd) tx_data <= cur_base + WB'(word_idx);
        else       tx_data <= 16'hDEAD;
    end

    // scoreboard
    logic [WB-1:0] exp_q[$];
    logic [WB-1:0] tx_q[$];
    logic [WB-1:0] mon_t;
    logic [WB-1:0] mosi_sh = '0;
    logic          prev_sck = 1'b0;
    int            rd_cnt = 0;
    int            rv_cnt = 0;
    int            done_cnt = 0;

    always @(negedge clk) begin
        if (tx_rd) begin
            check("tx_rd_idx", 32'(word_idx), rd_cnt);
            check("ss_n_at_rd", 32'(ss_n), 32'(exp_ss_n));
            check("sck_idle_at_rd", 32'(sck), 0);
            mon_t = cur_base + WB'(rd_cnt);
            tx_q.push_back(mon_t);
            exp_q.push_back(mon_inv ? ~mon_t : mon_t);
            rd_cnt++;
        end
        if (sck === 1'b1 && prev_sck === 1'b0) mosi_sh = {mosi_sh[WB-2:0], mosi};
        if (rx_valid) begin
            if (exp_q.size() == 0) begin
                check("rx_unexpected", 1, 0);
            end else begin
                check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
                check("mosi_word", 32'(mosi_sh), 32'(tx_q.pop_front()));
                check("rx_idx", 32'(word_idx), rv_cnt);
                check("ss_n_at_rx", 32'(ss_n), 32'(exp_ss_n));
                check("sck_low_at_rx", 32'(sck), 0);
            end
            rv_cnt++;
        end
        if (done) done_cnt++;
        prev_sck = sck;
    end

    // driver tasks
    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_sel_err"}, 32'(sel_err), 0);
        check({tag, "_tx_rd"}, 32'(tx_rd), 0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 0);
        check({tag, "_word_idx"}, 32'(word_idx), 0);
        check({tag, "_rx_data"}, 32'(rx_data), 0);
        check({tag, "_sck"}, 32'(sck), 0);
        check({tag, "_mosi"}, 32'(mosi), 0);
        check({tag, "_ss_n"}, 32'(ss_n), 32'h3F);
    endtask

    task automatic begin_frame(input logic [2:0] sel, input logic [WB-1:0] base,
                               input bit inv, input logic [NS-1:0] ss);
        cur_base = base;
        mon_inv  = inv;
        exp_ss_n = ss;
        rd_cnt   = 0;
        rv_cnt   = 0;
        done_cnt = 0;
        exp_q.delete();
        tx_q.delete();
        @(negedge clk);
        slave_sel = sel;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("ss_n_after_start", 32'(ss_n), 32'(ss));
    endtask

    task automatic run_frame(input logic [2:0] sel, input logic [WB-1:0] base,
                             input bit inv, input logic [NS-1:0] ss, input bit ins_start);
        int lat;
        begin_frame(sel, base, inv, ss);
        lat = 1;
        while (!done && lat < FRAME_LAT + 50) begin
            @(negedge clk);
            lat++;
            if (ins_start && lat == 350) begin
                slave_sel = 3'd0;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("frame_latency", lat, FRAME_LAT);
        check("busy_at_done", 32'(busy), 0);
        check("ss_n_at_done", 32'(ss_n), 32'h3F);
        repeat (3) @(negedge clk);
        check("tx_rd_count", rd_cnt, FW);
        check("rx_valid_count", rv_cnt, FW);
        check("done_count", done_cnt, 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    typedef struct {
        logic [2:0]    sel;
        logic [WB-1:0] base;
        bit            inv;
        logic [NS-1:0] exp_ss_n;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int wait_cnt;
        vecs[0] = '{sel: 3'd3, base: 16'hA5C3, inv: 1'b0, exp_ss_n: 6'b110111};
        vecs[1] = '{sel: 3'd0, base: 16'h0100, inv: 1'b1, exp_ss_n: 6'b111110};
        vecs[2] = '{sel: 3'd5, base: 16'hFFF0, inv: 1'b0, exp_ss_n: 6'b011111};
        vecs[3] = '{sel: 3'd2, base: 16'h8001, inv: 1'b1, exp_ss_n: 6'b111011};

        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;

        foreach (vecs[i]) run_frame(vecs[i].sel, vecs[i].base, vecs[i].inv, vecs[i].exp_ss_n, 1'b0);

        // second start during word 5 must leave the frame untouched
        run_frame(3'd3, 16'h1234, 1'b0, 6'b110111, 1'b1);

        // out-of-range select is rejected
        @(negedge clk);
        slave_sel = 3'd7;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("sel_err_pulse", 32'(sel_err), 1);
        check("sel_err_busy", 32'(busy), 0);
        check("sel_err_ss_n", 32'(ss_n), 32'h3F);
        @(negedge clk);
        check("sel_err_clears", 32'(sel_err), 0);
        check("sel_err_no_rd", 32'(tx_rd), 0);

        // start and abort together in IDLE: nothing starts
        @(negedge clk);
        slave_sel = 3'd1;
        start     = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 32'(busy), 0);
        check("start_abort_ss_n", 32'(ss_n), 32'h3F);
        check("start_abort_tx_rd", 32'(tx_rd), 0);
        check("start_abort_sel_err", 32'(sel_err), 0);

        // abort in the middle of word 2
        begin_frame(3'd4, 16'h4000, 1'b1, 6'b101111);
        wait_cnt = 0;
        while (rd_cnt < 3 && wait_cnt < 1000) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("abort_reached_word2", 32'(rd_cnt), 3);
        repeat (32) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ss_n", 32'(ss_n), 32'h3F);
        check("abort_sck", 32'(sck), 0);
        check("abort_mosi", 32'(mosi), 0);
        check("abort_busy", 32'(busy), 0);
        repeat (200) @(negedge clk);
        check("abort_rx_count", rv_cnt, 2);
        check("abort_no_done", done_cnt, 0);
        check("abort_no_more_rd", rd_cnt, 3);

        // one-cycle reset mid-SHIFT, then a clean frame
        begin_frame(3'd1, 16'h0F0F, 1'b0, 6'b111101);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals("midreset");
        repeat (5) @(negedge clk);
        check("midreset_idle_busy", 32'(busy), 0);
        run_frame(3'd1, 16'h0F0F, 1'b0, 6'b111101, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
